sca_rdout_seq: RTL

//  Parametrised SCA readout sequencer: successor to the fixed 16-ch/8-sample CFEB readout controller.

---
 rtl/sca_rdout_seq.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/sca_rdout_seq.sv
// sca_rdout_seq: SCA readout sequencer, walks masked samples x NCHAN channels and frames a PIPE-aligned push stream
// Ports: CLK/RST_B clock and async active-low reset; REQ_* one readout request per L1A (VLD/RDY handshake);
//   OUT_AFULL downstream back-pressure; SCA_ADR/CHAN/RDENA drive the SCA and ADC; PUSH/HDR/LASTWORD write the output FIFO;
//   NODATA/L1ANOUT/OVLP describe the current event; BUSY while not idle; DONE pulses once the event is fully pushed.
module sca_rdout_seq #(
  parameter int NCHAN = 16,
  parameter int NSAMP = 8,
  parameter int BLKW = 4,
  parameter int PIPE = 4,
  parameter int GRAY = 1,
  localparam int CW = $clog2(NCHAN),
  localparam int SW = $clog2(NSAMP)
) (
  input  logic               CLK,
  input  logic               RST_B,
  input  logic               REQ_VLD,
  output logic               REQ_RDY,
  input  logic [BLKW-1:0]    REQ_BLK,
  input  logic [NSAMP-1:0]   REQ_SMASK,
  input  logic [5:0]         REQ_L1A,
  input  logic               REQ_NODATA,
  input  logic               OUT_AFULL,
  output logic [BLKW+SW-1:0] SCA_ADR,
  output logic [CW-1:0]      CHAN,
  output logic               RDENA,
  output logic               PUSH,
  output logic               HDR,
  output logic               LASTWORD,
  output logic               NODATA,
  output logic [5:0]         L1ANOUT,
  output logic               OVLP,
  output logic               BUSY,
  output logic               DONE
);
  localparam int DW = $clog2(PIPE + 1);
  typedef enum logic [2:0] {S_IDLE, S_HDR, S_SCAN, S_READ, S_TRL, S_DRAIN} state_t;
  state_t state;
  logic [NSAMP-1:0] mask;
  logic [BLKW-1:0] blk, prev_blk;
  logic prev_vld;
  logic [SW-1:0] cur;
  logic [CW-1:0] chan_b;
  logic [DW-1:0] dcnt;
  logic [PIPE-1:0] sr_v, sr_h, sr_t;
  logic hdr_tok, trl_tok;
  function automatic logic [CW-1:0] enc(input logic [CW-1:0] b);
    return GRAY != 0 ? b ^ (b >> 1) : b;
  endfunction
  function automatic logic [SW-1:0] low_idx(input logic [NSAMP-1:0] m);
    low_idx = '0;
    for (int i = NSAMP - 1; i >= 0; i--) if (m[i]) low_idx = SW'(i);
  endfunction
  // RDENA follows OUT_AFULL in the same cycle so no word is read while downstream is nearly full
  assign RDENA = (state == S_READ) && !OUT_AFULL;
  assign hdr_tok = state == S_HDR;
  assign trl_tok = state == S_TRL;
  assign PUSH = sr_v[PIPE-1];
  assign HDR = sr_h[PIPE-1];
  assign LASTWORD = sr_t[PIPE-1];
  always_ff @(posedge CLK or negedge RST_B) begin
    if (!RST_B) begin
      state <= S_IDLE;
      mask <= '0;
      blk <= '0;
      prev_blk <= '0;
      prev_vld <= 1'b0;
      cur <= '0;
      chan_b <= '0;
      dcnt <= '0;
      sr_v <= '0;
      sr_h <= '0;
      sr_t <= '0;
      REQ_RDY <= 1'b0;
      SCA_ADR <= '0;
      CHAN <= '0;
      NODATA <= 1'b0;
      L1ANOUT <= '0;
      OVLP <= 1'b0;
      BUSY <= 1'b0;
      DONE <= 1'b0;
    end else begin
      sr_v[0] <= RDENA | hdr_tok | trl_tok;
      sr_h[0] <= hdr_tok;
      sr_t[0] <= trl_tok;
      for (int i = 1; i < PIPE; i++) begin
        sr_v[i] <= sr_v[i-1];
        sr_h[i] <= sr_h[i-1];
        sr_t[i] <= sr_t[i-1];
      end
      DONE <= 1'b0;
      case (state)
        S_IDLE:
          if (REQ_VLD && REQ_RDY) begin
            mask <= REQ_SMASK;
            blk <= REQ_BLK;
            L1ANOUT <= REQ_L1A;
            NODATA <= REQ_NODATA || REQ_SMASK == '0;
            OVLP <= prev_vld && REQ_BLK == prev_blk;
            prev_blk <= REQ_BLK;
            prev_vld <= 1'b1;
            REQ_RDY <= 1'b0;
            BUSY <= 1'b1;
            state <= S_HDR;
          end else REQ_RDY <= 1'b1;
        S_HDR: state <= NODATA ? S_TRL : S_SCAN;
        S_SCAN:
          if (mask == '0) state <= S_TRL;
          else begin
            cur <= low_idx(mask);
            SCA_ADR <= {blk, low_idx(mask)};
            chan_b <= '0;
            CHAN <= '0;
            state <= S_READ;
          end
        S_READ:
          if (RDENA) begin
            // the last channel retires the sample; the counter only restarts from SCAN
            if (chan_b == CW'(NCHAN - 1)) begin
              mask[cur] <= 1'b0;
              state <= S_SCAN;
            end else begin
              chan_b <= chan_b + 1'b1;
              CHAN <= enc(chan_b + 1'b1);
            end
          end
        S_TRL: begin
          dcnt <= '0;
          state <= S_DRAIN;
        end
        S_DRAIN:
          // trailer leaves the delay line in the last drain cycle
          if (dcnt == DW'(PIPE - 1)) begin
            DONE <= 1'b1;
            BUSY <= 1'b0;
            REQ_RDY <= 1'b1;
            state <= S_IDLE;
          end else dcnt <= dcnt + 1'b1;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
